// File: rtl/video_buffer_scanout_reader_if.sv
// Bus bundle for the scanout reader: read-only port into the frame buffer
// plus the outgoing pixel-word stream.
interface video_buffer_scanout_reader_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                chipselect;
    logic                read;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;
    logic [DATA_W-1:0]   st_data;
    logic                st_valid;
    logic                st_ready;
    logic                st_sop;
    logic                st_eop;

    modport master (
        output address, chipselect, read, byteenable,
        output st_data, st_valid, st_sop, st_eop,
        input  readdata, st_ready
    );

    modport slave (
        input  address, chipselect, read, byteenable,
        input  st_data, st_valid, st_sop, st_eop,
        output readdata, st_ready
    );
endinterface

// File: rtl/video_buffer_scanout_reader.sv
// Sequential frame fetcher for a fixed-latency buffer port, streaming words out
// through a small FWFT FIFO. Reads are only issued against free FIFO credit.
module video_buffer_scanout_reader #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 32,
    parameter int FRAME_WORDS  = 86400,
    parameter int BASE_ADDR    = 0,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic continuous,
    input  logic abort,
    output logic busy,
    output logic frame_done,
    video_buffer_scanout_reader_if.master bus
);
    localparam int CNT_W = $clog2(FRAME_WORDS + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(2 * FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FLUSH} state_t;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  addr_q;
    logic [CNT_W-1:0]   issued;
    logic               rd_en, restart, done_nx, fifo_clear;
    logic [READ_LATENCY-1:0] pv, ps, pe;
    logic [OCC_W-1:0]   inflight, fifo_count;
    logic               credit;

    logic [DATA_W+1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [DATA_W+1:0]  head;
    logic               fifo_empty, push, pop, eop_xfer;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + OCC_W'(pv[i]);
        end
    end

    // Words still in the read pipe already own a FIFO slot, so a full count never overflows.
    assign credit     = (fifo_count + inflight) < OCC_W'(FIFO_DEPTH);
    assign fifo_empty = (fifo_count == '0);
    assign head       = mem[rd_ptr];
    assign push       = pv[READ_LATENCY-1] && (state != FLUSH);
    assign pop        = !fifo_empty && bus.st_ready;
    assign eop_xfer   = pop && head[0];

    always_comb begin
        state_nx   = state;
        rd_en      = 1'b0;
        restart    = 1'b0;
        done_nx    = 1'b0;
        fifo_clear = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx = FETCH;
                    restart  = 1'b1;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_nx = FLUSH;
                end else if (credit) begin
                    rd_en = 1'b1;
                    if (issued == CNT_W'(FRAME_WORDS - 1)) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_nx = FLUSH;
                end else if (eop_xfer) begin
                    done_nx = 1'b1;
                    if (continuous) begin
                        state_nx = FETCH;
                        restart  = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            FLUSH: begin
                if (inflight == '0) begin
                    state_nx   = IDLE;
                    fifo_clear = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            addr_q     <= ADDR_W'(BASE_ADDR);
            issued     <= '0;
            frame_done <= 1'b0;
            pv         <= '0;
            ps         <= '0;
            pe         <= '0;
        end else begin
            state      <= state_nx;
            frame_done <= done_nx;
            if (restart) begin
                addr_q <= ADDR_W'(BASE_ADDR);
                issued <= '0;
            end else if (rd_en) begin
                addr_q <= addr_q + ADDR_W'(1);
                issued <= issued + CNT_W'(1);
            end
            pv[0] <= rd_en;
            ps[0] <= rd_en && (issued == '0);
            pe[0] <= rd_en && (issued == CNT_W'(FRAME_WORDS - 1));
            for (int i = 1; i < READ_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                ps[i] <= ps[i-1];
                pe[i] <= pe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || fifo_clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + OCC_W'(push) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {bus.readdata, ps[READ_LATENCY-1], pe[READ_LATENCY-1]};
    end

    assign busy           = (state != IDLE);
    assign bus.address    = addr_q;
    assign bus.read       = rd_en;
    assign bus.chipselect = rd_en;
    assign bus.byteenable = '1;
    assign bus.st_valid   = !fifo_empty;
    assign bus.st_data    = fifo_empty ? '0 : head[DATA_W+1:2];
    assign bus.st_sop     = !fifo_empty && head[1];
    assign bus.st_eop     = !fifo_empty && head[0];
endmodule

// File: tb/tb_video_buffer_scanout_reader.sv
// Directed bench for the scanout reader: one instance at read latency 1, one at 3,
// each backed by a memory model whose word equals its address.
module tb_video_buffer_scanout_reader;
    localparam int          FW    = 16;
    localparam logic [16:0] BASE  = 17'h100;
    localparam int          DEPTH = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic start1, cont1, abort1, busy1, fd1;
    logic start3, cont3, abort3, busy3, fd3;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc = 0;
    int sc  = 0;

    logic [31:0] words1 [$];
    logic        sops1  [$];
    logic        eops1  [$];
    int          xfer1  [$];
    int          fd1_cyc[$];
    logic [16:0] addr1  [$];
    int out1 = 0, over1 = 0, stall1 = 0;

    logic [31:0] words3 [$];
    int reads3 = 0, out3 = 0, over3 = 0;
    logic [31:0] d3 [3];

    always #5 clk = ~clk;

    video_buffer_scanout_reader_if #(.ADDR_W(17), .DATA_W(32)) bus1 ();
    video_buffer_scanout_reader_if #(.ADDR_W(17), .DATA_W(32)) bus3 ();

    video_buffer_scanout_reader #(
        .ADDR_W(17), .DATA_W(32), .FRAME_WORDS(FW), .BASE_ADDR(32'h100),
        .READ_LATENCY(1), .FIFO_DEPTH(DEPTH)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .continuous(cont1),
        .abort(abort1), .busy(busy1), .frame_done(fd1), .bus(bus1)
    );

    video_buffer_scanout_reader #(
        .ADDR_W(17), .DATA_W(32), .FRAME_WORDS(FW), .BASE_ADDR(32'h100),
        .READ_LATENCY(3), .FIFO_DEPTH(DEPTH)
    ) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .continuous(cont3),
        .abort(abort3), .busy(busy3), .frame_done(fd3), .bus(bus3)
    );

    // Memory models: data returned READ_LATENCY edges after the address is presented.
    always @(posedge clk) bus1.readdata <= {15'd0, bus1.address};

    always @(posedge clk) begin
        d3[0] <= {15'd0, bus3.address};
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end
    assign bus3.readdata = d3[2];

    // Outstanding = reads issued minus words accepted, i.e. FIFO fill plus in-flight.
    always @(posedge clk) begin
        if (bus1.read) begin
            if (out1 >= DEPTH) stall1++;
            addr1.push_back(bus1.address);
            out1++;
        end
        if (bus1.st_valid && bus1.st_ready) begin
            words1.push_back(bus1.st_data);
            sops1.push_back(bus1.st_sop);
            eops1.push_back(bus1.st_eop);
            xfer1.push_back(cyc);
            out1--;
        end
        if (out1 > DEPTH) over1++;
        if (fd1) fd1_cyc.push_back(cyc);
        cyc++;
    end

    always @(posedge clk) begin
        if (bus3.read) begin
            reads3++;
            out3++;
        end
        if (bus3.st_valid && bus3.st_ready) begin
            words3.push_back(bus3.st_data);
            out3--;
        end
        if (out3 > DEPTH) over3++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int which, input logic s, input logic c, input logic a);
        if (which == 1) begin
            start1 = s; cont1 = c; abort1 = a;
        end else begin
            start3 = s; cont3 = c; abort3 = a;
        end
    endtask

    task automatic pulse(input int which, input logic c);
        sc = cyc;
        applyStimulus(which, 1'b1, c, 1'b0);
        step(1);
        applyStimulus(which, 1'b0, c, 1'b0);
    endtask

    task automatic wait_idle(input int which, input int max_cycles);
        int n = 0;
        while (((which == 1) ? busy1 : busy3) && n < max_cycles) begin
            step(1);
            n++;
        end
        checkOutput("idle_timeout", 64'((which == 1) ? busy1 : busy3), 64'd0);
        step(2);
    endtask

    task automatic clear1();
        words1.delete(); sops1.delete(); eops1.delete(); xfer1.delete();
        fd1_cyc.delete(); addr1.delete();
        out1 = 0; over1 = 0; stall1 = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_busy"},  64'(busy1), 64'd0);
        checkOutput({tag, "_done"},  64'(fd1), 64'd0);
        checkOutput({tag, "_read"},  64'(bus1.read), 64'd0);
        checkOutput({tag, "_cs"},    64'(bus1.chipselect), 64'd0);
        checkOutput({tag, "_addr"},  64'(bus1.address), 64'(BASE));
        checkOutput({tag, "_valid"}, 64'(bus1.st_valid), 64'd0);
        checkOutput({tag, "_sop"},   64'(bus1.st_sop), 64'd0);
        checkOutput({tag, "_eop"},   64'(bus1.st_eop), 64'd0);
        checkOutput({tag, "_data"},  64'(bus1.st_data), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int nsop, neop;

        reset_n = 1'b0;
        applyStimulus(1, 1'b0, 1'b0, 1'b0);
        applyStimulus(3, 1'b0, 1'b0, 1'b0);
        bus1.st_ready = 1'b1;
        bus3.st_ready = 1'b0;
        step(3);
        check_reset_outputs("reset");
        checkOutput("reset_be", 64'(bus1.byteenable), 64'hF);
        checkOutput("reset_busy3", 64'(busy3), 64'd0);
        reset_n = 1'b1;
        step(2);

        // Single frame, sink always ready
        clear1();
        pulse(1, 1'b0);
        wait_idle(1, 100);
        checkOutput("f1_nreads", 64'(addr1.size()), 64'd16);
        checkOutput("f1_nwords", 64'(words1.size()), 64'd16);
        for (int i = 0; i < FW; i++) begin
            checkOutput($sformatf("f1_addr%0d", i), 64'(addr1[i]), 64'(BASE + 17'(i)));
            checkOutput($sformatf("f1_word%0d", i), 64'(words1[i]), 64'(32'h100 + i));
        end
        checkOutput("f1_first_latency", 64'(xfer1[0]), 64'(sc + 3));
        checkOutput("f1_last_xfer", 64'(xfer1[15]), 64'(sc + 18));
        checkOutput("f1_sop", 64'(sops1[0]), 64'd1);
        checkOutput("f1_eop", 64'(eops1[15]), 64'd1);
        nsop = 0; neop = 0;
        for (int i = 0; i < FW; i++) begin
            nsop += int'(sops1[i]);
            neop += int'(eops1[i]);
        end
        checkOutput("f1_sop_count", 64'(nsop), 64'd1);
        checkOutput("f1_eop_count", 64'(neop), 64'd1);
        checkOutput("f1_done_count", 64'(fd1_cyc.size()), 64'd1);
        checkOutput("f1_done_cycle", 64'(fd1_cyc[0]), 64'(sc + 19));
        checkOutput("f1_busy_after", 64'(busy1), 64'd0);

        // Random backpressure at roughly 30% ready
        clear1();
        pulse(1, 1'b0);
        for (int i = 0; i < 150; i++) begin
            bus1.st_ready = ($urandom_range(0, 99) < 30);
            step(1);
        end
        bus1.st_ready = 1'b1;
        wait_idle(1, 100);
        checkOutput("bp_nwords", 64'(words1.size()), 64'd16);
        for (int i = 0; i < FW; i++) begin
            checkOutput($sformatf("bp_word%0d", i), 64'(words1[i]), 64'(32'h100 + i));
        end
        checkOutput("bp_sop", 64'(sops1[0]), 64'd1);
        checkOutput("bp_eop", 64'(eops1[15]), 64'd1);
        checkOutput("bp_overflow", 64'(over1), 64'd0);
        checkOutput("bp_read_without_credit", 64'(stall1), 64'd0);
        checkOutput("bp_done_count", 64'(fd1_cyc.size()), 64'd1);

        // Latency 3 with the sink stalled: credit caps issue at FIFO depth
        words3.delete(); reads3 = 0; out3 = 0; over3 = 0;
        pulse(3, 1'b0);
        step(20);
        checkOutput("rl3_reads_stalled", 64'(reads3), 64'd8);
        checkOutput("rl3_read_low", 64'(bus3.read), 64'd0);
        checkOutput("rl3_valid", 64'(bus3.st_valid), 64'd1);
        checkOutput("rl3_head_data", 64'(bus3.st_data), 64'h100);
        checkOutput("rl3_head_sop", 64'(bus3.st_sop), 64'd1);
        bus3.st_ready = 1'b1;
        wait_idle(3, 100);
        checkOutput("rl3_nreads", 64'(reads3), 64'd16);
        checkOutput("rl3_nwords", 64'(words3.size()), 64'd16);
        for (int i = 0; i < FW; i++) begin
            checkOutput($sformatf("rl3_word%0d", i), 64'(words3[i]), 64'(32'h100 + i));
        end
        checkOutput("rl3_overflow", 64'(over3), 64'd0);

        // Continuous mode for three frames, released during the third
        clear1();
        pulse(1, 1'b1);
        n = 0;
        while (fd1_cyc.size() < 2 && n < 200) begin
            step(1);
            n++;
        end
        checkOutput("cont_two_done_timeout", 64'(fd1_cyc.size() >= 2), 64'd1);
        applyStimulus(1, 1'b0, 1'b0, 1'b0);
        wait_idle(1, 100);
        checkOutput("cont_nwords", 64'(words1.size()), 64'd48);
        checkOutput("cont_done_count", 64'(fd1_cyc.size()), 64'd3);
        for (int i = 0; i < 3 * FW; i++) begin
            checkOutput($sformatf("cont_word%0d", i), 64'(words1[i]), 64'(32'h100 + (i % FW)));
        end
        nsop = 0; neop = 0;
        for (int i = 0; i < 3 * FW; i++) begin
            nsop += int'(sops1[i]);
            neop += int'(eops1[i]);
        end
        checkOutput("cont_sop_count", 64'(nsop), 64'd3);
        checkOutput("cont_eop_count", 64'(neop), 64'd3);
        checkOutput("cont_sop16", 64'(sops1[16]), 64'd1);
        checkOutput("cont_sop32", 64'(sops1[32]), 64'd1);
        checkOutput("cont_eop31", 64'(eops1[31]), 64'd1);
        checkOutput("cont_eop47", 64'(eops1[47]), 64'd1);
        checkOutput("cont_gap1", 64'(xfer1[16] - xfer1[15]), 64'd3);
        checkOutput("cont_gap2", 64'(xfer1[32] - xfer1[31]), 64'd3);

        // Abort while the sixth word is on the stream
        clear1();
        pulse(1, 1'b0);
        n = 0;
        while (words1.size() < 5 && n < 50) begin
            step(1);
            n++;
        end
        checkOutput("abort_reach_timeout", 64'(words1.size()), 64'd5);
        checkOutput("abort_read_before", 64'(bus1.read), 64'd1);
        applyStimulus(1, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("abort_read_drop", 64'(bus1.read), 64'd0);
        checkOutput("abort_busy", 64'(busy1), 64'd1);
        step(4);
        applyStimulus(1, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_idle", 64'(busy1), 64'd0);
        checkOutput("abort_valid", 64'(bus1.st_valid), 64'd0);
        checkOutput("abort_no_done", 64'(fd1_cyc.size()), 64'd0);
        checkOutput("abort_nreads", 64'(addr1.size()), 64'd7);
        step(2);
        clear1();
        pulse(1, 1'b0);
        wait_idle(1, 100);
        checkOutput("post_abort_addr0", 64'(addr1[0]), 64'(BASE));
        checkOutput("post_abort_word0", 64'(words1[0]), 64'h100);
        checkOutput("post_abort_sop", 64'(sops1[0]), 64'd1);
        checkOutput("post_abort_nwords", 64'(words1.size()), 64'd16);
        checkOutput("post_abort_done", 64'(fd1_cyc.size()), 64'd1);

        // One-cycle reset in the middle of a frame
        clear1();
        pulse(1, 1'b0);
        step(6);
        reset_n = 1'b0;
        step(1);
        check_reset_outputs("midreset");
        reset_n = 1'b1;
        step(1);
        clear1();
        pulse(1, 1'b0);
        wait_idle(1, 100);
        checkOutput("post_reset_nwords", 64'(words1.size()), 64'd16);
        checkOutput("post_reset_word0", 64'(words1[0]), 64'h100);
        checkOutput("post_reset_word15", 64'(words1[15]), 64'h10F);
        checkOutput("post_reset_sop", 64'(sops1[0]), 64'd1);
        checkOutput("post_reset_eop", 64'(eops1[15]), 64'd1);
        checkOutput("post_reset_done", 64'(fd1_cyc.size()), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/video_buffer_scanout_reader.md
Name: video_buffer_scanout_reader

Overview:
- Read-side master for the dual-port on-chip video frame buffer. Connects to the buffer's second slave port (fixed read latency, no waitrequest) while the HPS/writer fills it through the first port.
- Fetches one frame of 32-bit words sequentially and presents them as a streaming pixel-word source with start/end-of-packet markers for the downstream video pipeline.
- Credit-based fetch guarantees no returned word is ever dropped, regardless of downstream backpressure.

Parameters:
- ADDR_W, 17, word-address width of the buffer port.
- DATA_W, 32, data width. Byteenable width is DATA_W/8.
- FRAME_WORDS, 86400, words per frame. Valid range is 2 to 2^ADDR_W.
- BASE_ADDR, 0, first word address of the frame.
- READ_LATENCY, 1, cycles from read issue to readdata valid. Valid range is 1 to 4.
- FIFO_DEPTH, 8, output FIFO entries. Must be a power of 2 and at least READ_LATENCY+1.

Ports:
- clk, in, 1, sole clock. Same clock as the buffer's clk2.
- reset_n, in, 1, synchronous, active-low reset.
- start, in, 1, one-cycle pulse that begins a frame. Ignored unless in IDLE.
- continuous, in, 1, when 1, restart automatically after each frame_done.
- abort, in, 1, level input that cancels the current frame.
- busy, out, 1, high in any state other than IDLE.
- frame_done, out, 1, one-cycle pulse when the last word of a frame is accepted downstream.
- address, out, ADDR_W, word address to the buffer.
- chipselect, out, 1, equals read.
- read, out, 1, read strobe. Every asserted cycle is one accepted read.
- byteenable, out, DATA_W/8, constant all ones.
- readdata, in, DATA_W, buffer read data.
- st_data, out, DATA_W, stream data.
- st_valid, out, 1, stream valid.
- st_ready, in, 1, downstream ready.
- st_sop, out, 1, marks the first word of a frame.
- st_eop, out, 1, marks the last word of a frame.

Behaviour:
- Reset values (reset_n=0 at a clk edge):
  - Outputs: busy=0, frame_done=0, read=0, chipselect=0, address=BASE_ADDR, st_valid=0, st_sop=0, st_eop=0, st_data=0.
  - Internal state: FIFO empty, issue count 0, pending-valid pipe cleared, state IDLE.
  - Reset mid-frame discards all in-flight data immediately.
- FSM states: IDLE, FETCH, DRAIN, FLUSH.
  - IDLE: on start=1, go to FETCH with address=BASE_ADDR and issued=0.
  - FETCH: assert read when credit is available, where credit = fifo_count + inflight < FIFO_DEPTH.
    - On each read: address++ and issued++.
    - The read that makes issued=FRAME_WORDS goes to DRAIN in the next cycle.
    - abort=1 goes to FLUSH, and no read is issued in that cycle.
  - DRAIN: no reads are issued.
    - When the FIFO handshake transfers the EOP word, pulse frame_done and go to FETCH (address reset, issued reset) if continuous=1, otherwise go to IDLE.
    - abort=1 goes to FLUSH.
  - FLUSH: read=0. Wait until inflight=0, discarding returning words, then empty the FIFO and go to IDLE. No frame_done is generated.
- Read return:
  - A READ_LATENCY-deep shift pipe of valid bits; inflight is its population count.
  - When the pipe output is 1, readdata is pushed into the FIFO with a tag: sop if its index is 0, eop if its index is FRAME_WORDS-1.
  - The tag travels in the pipe alongside the valid bit.
  - Credit accounting makes FIFO overflow impossible. The bench asserts this.
- Stream output:
  - st_valid = FIFO non-empty. st_data, st_sop and st_eop come from the FIFO head.
  - Transfer happens when st_valid & st_ready. Once asserted, data must stay stable until transfer.
  - FIFO is first-word-fall-through. A push and pop in the same cycle are both honoured.
  - Pushing into an empty FIFO shows the word on st_valid in the next cycle.
- Latency: from start to the first st_valid is 1 + 1 + READ_LATENCY cycles (IDLE→FETCH, first read, return, FIFO).
- Throughput: with st_ready held at 1, one word per cycle sustained. read stays high continuously once the pipeline fills.
- Address: address increments monotonically from BASE_ADDR to BASE_ADDR+FRAME_WORDS-1 and never wraps within a frame. Counters are sized for FRAME_WORDS.
- Simultaneous events:
  - abort has priority over start and continuous restart.
  - A start pulse arriving in FETCH or DRAIN is ignored.
  - If continuous falls during a frame, that frame completes and the block then goes to IDLE.

Test Plan:
- Set FRAME_WORDS=16, BASE_ADDR=0x100, READ_LATENCY=1, memory word = address, st_ready=1, pulse start → expect:
  - addresses 0x100..0x10F, each issued once;
  - 16 stream words 0x100..0x10F in consecutive cycles;
  - st_sop on 0x100 and st_eop on 0x10F;
  - frame_done one cycle after the EOP transfer;
  - busy=0 afterwards.
- Same setup, st_ready random at 30% duty → identical data order and no FIFO overflow; read is stalled whenever fifo_count+inflight=8.
- READ_LATENCY=3, st_ready=0 for 20 cycles after start → exactly 8 reads issued, then read=0; stream resumes correctly when st_ready=1.
- continuous=1 for 3 frames → 48 words, sop at words 0/16/32, eop at 15/31/47, 3 frame_done pulses, no gap above READ_LATENCY+2 cycles between frames.
- abort asserted at the 6th word → read drops the same cycle, state goes to FLUSH, st_valid falls after the drain, no frame_done, busy=0; the next start restarts at 0x100 with sop.
- reset_n low for 1 cycle mid-frame → all outputs at their reset values the following cycle; the next frame is clean.
